// File: rtl/rvb_shifter_issue.sv
// Issue stage for rvb_shifter: decodes the shifter class, substitutes shamt for immediate forms and
// presents the din_* bundle through a 2-entry skid buffer. Optional macro: RVB_ISSUE_ILLEGAL_EN.
module rvb_shifter_issue #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SBOP = 0,
  parameter int unsigned BFP  = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [31:0]     din_insn,
  input  logic [XLEN-1:0] din_rs1,
  input  logic [XLEN-1:0] din_rs2,
  input  logic [XLEN-1:0] din_rs3,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [XLEN-1:0] dout_rs1,
  output logic [XLEN-1:0] dout_rs2,
  output logic [XLEN-1:0] dout_rs3,
  output logic            dout_insn3,
  output logic            dout_insn14,
  output logic            dout_insn26,
  output logic            dout_insn27,
  output logic            dout_insn29,
  output logic            dout_insn30,
  output logic            dout_illegal
);

  localparam int unsigned PW = 3 * XLEN + 6;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            op_shift;
  logic            sbop;
  logic            legal;
  logic [XLEN-1:0] shamt;
  logic [PW-1:0]   payload;

  logic            accept;
  logic            drain;
  logic            o_valid_q, o_valid_d;
  logic            s_valid_q, s_valid_d;
  logic            ready_q, ready_d;
  logic [PW-1:0]   o_q, o_d;
  logic [PW-1:0]   s_q, s_d;

  logic unused_insn;
  assign unused_insn = ^{din_insn[19:15], din_insn[11:7]};

  always_comb begin
    opcode   = din_insn[6:0];
    funct3   = din_insn[14:12];
    op_shift = (opcode == 7'b0110011) || (opcode == 7'b0010011);
    if (XLEN == 64) begin
      op_shift = op_shift || (opcode == 7'b0111011) || (opcode == 7'b0011011);
    end
    // Single-bit ops carry funct7 bit 2; funnel shifts use bit 26, where bit 27 belongs to rs3.
    sbop  = din_insn[27] && !din_insn[26];
    legal = op_shift && ((funct3 == 3'b001) || (funct3 == 3'b101)) && ((SBOP != 0) || !sbop);
    if ((BFP != 0) && (opcode == 7'b0110011) && (funct3 == 3'b111) &&
        (din_insn[31:25] == 7'b0100100)) begin
      legal = 1'b1;
    end
    shamt      = '0;
    shamt[5:0] = din_insn[25:20];
    if (XLEN == 32) begin
      shamt[5] = 1'b0;
    end
    payload = {din_rs1, (din_insn[5] ? din_rs2 : shamt), din_rs3,
               ((XLEN == 64) && din_insn[3]), din_insn[14], din_insn[26], din_insn[27],
               din_insn[29], din_insn[30]};
  end

  always_comb begin
    accept    = din_valid && ready_q;
    drain     = o_valid_q && dout_ready;
    o_valid_d = o_valid_q;
    s_valid_d = s_valid_q;
    o_d       = o_q;
    s_d       = s_q;
    if (s_valid_q && drain) begin
      o_d       = s_q;
      s_valid_d = 1'b0;
    end else if (accept && legal && (!o_valid_q || dout_ready)) begin
      o_valid_d = 1'b1;
      o_d       = payload;
    end else if (accept && legal) begin
      s_valid_d = 1'b1;
      s_d       = payload;
    end else if (drain) begin
      o_valid_d = 1'b0;
    end
    ready_d = !s_valid_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      o_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      ready_q   <= 1'b1;
      o_q       <= '0;
      s_q       <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      s_valid_q <= s_valid_d;
      ready_q   <= ready_d;
      o_q       <= o_d;
      s_q       <= s_d;
    end
  end

`ifdef RVB_ISSUE_ILLEGAL_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = accept && !legal;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign dout_illegal = illegal_q;
`else
  assign dout_illegal = 1'b0;
`endif

  assign din_ready  = ready_q;
  assign dout_valid = o_valid_q;
  assign {dout_rs1, dout_rs2, dout_rs3, dout_insn3, dout_insn14, dout_insn26, dout_insn27,
          dout_insn29, dout_insn30} = o_q;

endmodule

// File: tb/tb_rvb_shifter_issue.sv
// Bench for rvb_shifter_issue: queue-based reference model checked every cycle, directed cases
// with literal expectations, then randomized traffic with occasional resets.
module tb_rvb_shifter_issue;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = 3 * XLEN + 6;
`ifdef RVB_ISSUE_ILLEGAL_EN
  localparam bit IllEn = 1'b1;
`else
  localparam bit IllEn = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic            din_valid, din_valid2, din_ready, din_ready2;
  logic [31:0]     din_insn;
  logic [XLEN-1:0] din_rs1, din_rs2, din_rs3;
  logic            dout_valid, dout_ready, dout_illegal;
  logic [XLEN-1:0] dout_rs1, dout_rs2, dout_rs3;
  logic            dout_insn3, dout_insn14, dout_insn26, dout_insn27, dout_insn29, dout_insn30;
  logic            d2_valid, d2_illegal;
  logic [XLEN-1:0] d2_rs1, d2_rs2, d2_rs3;
  logic            d2_i3, d2_i14, d2_i26, d2_i27, d2_i29, d2_i30;
  logic [PW-1:0]   dout_bus;

  always #5 clock = ~clock;

  rvb_shifter_issue #(.XLEN(XLEN), .SBOP(0), .BFP(0)) dut (
    .clock(clock), .reset(reset), .din_valid(din_valid), .din_ready(din_ready),
    .din_insn(din_insn), .din_rs1(din_rs1), .din_rs2(din_rs2), .din_rs3(din_rs3),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_rs1(dout_rs1),
    .dout_rs2(dout_rs2), .dout_rs3(dout_rs3), .dout_insn3(dout_insn3),
    .dout_insn14(dout_insn14), .dout_insn26(dout_insn26), .dout_insn27(dout_insn27),
    .dout_insn29(dout_insn29), .dout_insn30(dout_insn30), .dout_illegal(dout_illegal)
  );

  rvb_shifter_issue #(.XLEN(XLEN), .SBOP(1), .BFP(1)) dut_bfp (
    .clock(clock), .reset(reset), .din_valid(din_valid2), .din_ready(din_ready2),
    .din_insn(din_insn), .din_rs1(din_rs1), .din_rs2(din_rs2), .din_rs3(din_rs3),
    .dout_valid(d2_valid), .dout_ready(1'b1), .dout_rs1(d2_rs1),
    .dout_rs2(d2_rs2), .dout_rs3(d2_rs3), .dout_insn3(d2_i3),
    .dout_insn14(d2_i14), .dout_insn26(d2_i26), .dout_insn27(d2_i27),
    .dout_insn29(d2_i29), .dout_insn30(d2_i30), .dout_illegal(d2_illegal)
  );

  assign dout_bus = {dout_rs1, dout_rs2, dout_rs3, dout_insn3, dout_insn14, dout_insn26,
                     dout_insn27, dout_insn29, dout_insn30};

  int unsigned   n_chk  = 0;
  int unsigned   n_fail = 0;
  bit            cmp_en = 1'b0;
  logic [PW-1:0] q[$];
  bit            ready_m = 1'b1;
  bit            ill_m   = 1'b0;

  function automatic bit is_legal(logic [31:0] insn, bit sbop_en, bit bfp_en);
    logic [6:0] op;
    logic [2:0] f3;
    bit         shift_class;
    op = insn[6:0];
    f3 = insn[14:12];
    shift_class = (op == 7'h33) || (op == 7'h13) || ((XLEN == 64) && ((op == 7'h3B) || (op == 7'h1B)));
    if (shift_class && (f3 == 3'd1 || f3 == 3'd5) && (sbop_en || !(insn[27] && !insn[26])))
      return 1'b1;
    return bfp_en && (op == 7'h33) && (f3 == 3'd7) && (insn[31:25] == 7'h24);
  endfunction

  function automatic logic [PW-1:0] expect_payload(logic [31:0] insn, logic [XLEN-1:0] a,
                                                   logic [XLEN-1:0] b, logic [XLEN-1:0] c);
    logic [XLEN-1:0] op2;
    int unsigned     sh;
    sh  = (XLEN == 64) ? 32'(insn[25:20]) : 32'(insn[24:20]);
    op2 = insn[5] ? b : XLEN'(sh);
    return {a, op2, c, (XLEN == 64) ? insn[3] : 1'b0, insn[14], insn[26], insn[27], insn[29],
            insn[30]};
  endfunction

  task automatic chk1(string name, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: at most two beats in flight, FIFO order, ready means fewer than two held.
  initial begin
    bit acc;
    forever begin
      @(posedge clock);
      if (reset) begin
        q.delete();
        ready_m = 1'b1;
        ill_m   = 1'b0;
      end else begin
        acc = din_valid && ready_m;
        if (q.size() > 0 && dout_ready) void'(q.pop_front());
        if (acc && is_legal(din_insn, 1'b0, 1'b0))
          q.push_back(expect_payload(din_insn, din_rs1, din_rs2, din_rs3));
        ill_m   = IllEn && acc && !is_legal(din_insn, 1'b0, 1'b0);
        ready_m = q.size() < 2;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (cmp_en) begin
        chk1("din_ready", din_ready, ready_m);
        chk1("dout_valid", dout_valid, q.size() != 0);
        chk1("dout_illegal", dout_illegal, ill_m);
        if (q.size() != 0) chkw("payload", 128'(dout_bus), 128'(q[0]));
      end
    end
  end

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 4))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h3B;
      3: w[6:0] = 7'h1B;
      default: w[6:0] = 7'h63;
    endcase
    if ($urandom_range(0, 3) != 0) w[14:12] = $urandom_range(0, 1) ? 3'd1 : 3'd5;
    if ($urandom_range(0, 1) != 0) w[27] = 1'b0;
    return w;
  endfunction

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; din_valid = 1'b0; din_valid2 = 1'b0; dout_ready = 1'b1;
    din_insn = '0; din_rs1 = '0; din_rs2 = '0; din_rs3 = '0;
    @(posedge clock);
    cmp_en = 1'b1;
    step(); step();
    chk1("rst_din_ready", din_ready, 1'b1);
    chk1("rst_dout_valid", dout_valid, 1'b0);
    chk1("rst_illegal", dout_illegal, 1'b0);
    chkw("rst_payload", 128'(dout_bus), 128'h0);
    reset = 1'b0;

    // ror x1,x2,x3
    din_valid = 1'b1; din_insn = 32'h603150B3;
    din_rs1 = 32'h80000001; din_rs2 = 32'd4; din_rs3 = 32'h12345678;
    step();
    chk1("ror_valid", dout_valid, 1'b1);
    chkw("ror_rs1", 128'(dout_rs1), 128'h80000001);
    chkw("ror_rs2", 128'(dout_rs2), 128'h4);
    chkw("ror_bits", 128'({dout_insn30, dout_insn29, dout_insn27, dout_insn26, dout_insn14}),
         128'b11001);

    // slli: shamt replaces rs2
    din_insn = 32'h00511093; din_rs2 = 32'hFFFFFFFF;
    step();
    chkw("slli_rs2", 128'(dout_rs2), 128'h5);
    chk1("slli_insn14", dout_insn14, 1'b0);

    // add is dropped
    din_insn = 32'h003100B3;
    step();
    chk1("add_valid", dout_valid, 1'b0);
    chk1("add_illegal", dout_illegal, IllEn);
    din_valid = 1'b0;
    step();
    chk1("add_illegal_pulse", dout_illegal, 1'b0);

    // Stall with three back-to-back beats
    dout_ready = 1'b0; din_valid = 1'b1; din_insn = 32'h603150B3; din_rs1 = 32'hA;
    step();
    chk1("stall_ready_a", din_ready, 1'b1);
    din_rs1 = 32'hB;
    step();
    chk1("stall_ready_b", din_ready, 1'b0);
    chkw("stall_hold_a", 128'(dout_rs1), 128'hA);
    din_rs1 = 32'hC;
    step();
    chk1("stall_ready_c", din_ready, 1'b0);
    chkw("stall_hold_a2", 128'(dout_rs1), 128'hA);
    dout_ready = 1'b1;
    step();
    chkw("order_b", 128'(dout_rs1), 128'hB);
    chk1("order_b_valid", dout_valid, 1'b1);
    step();
    chkw("order_c", 128'(dout_rs1), 128'hC);
    chk1("order_c_valid", dout_valid, 1'b1);
    din_valid = 1'b0;
    step();
    chk1("order_drained", dout_valid, 1'b0);

    // Reset with both entries full
    dout_ready = 1'b0; din_valid = 1'b1; din_rs1 = 32'h55;
    step(); step();
    din_valid = 1'b0;
    chk1("full_before_rst", din_ready, 1'b0);
    reset = 1'b1;
    step();
    chk1("mid_rst_valid", dout_valid, 1'b0);
    chk1("mid_rst_ready", din_ready, 1'b1);
    chkw("mid_rst_payload", 128'(dout_bus), 128'h0);
    reset = 1'b0; dout_ready = 1'b1;

    // bfp: dropped without BFP, forwarded with it
    din_valid = 1'b1; din_valid2 = 1'b1; din_insn = 32'h483170B3; din_rs1 = 32'h77;
    step();
    chk1("bfp_off_valid", dout_valid, 1'b0);
    chk1("bfp_off_illegal", dout_illegal, IllEn);
    chk1("bfp_on_valid", d2_valid, 1'b1);
    chkw("bfp_on_bits", 128'({d2_i14, d2_i30, d2_i27}), 128'b111);
    chkw("bfp_on_rs1", 128'(d2_rs1), 128'h77);
    chk1("bfp_on_illegal", d2_illegal, 1'b0);
    din_valid = 1'b0; din_valid2 = 1'b0;
    step();

    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      din_valid  = ($urandom_range(0, 3) != 0);
      dout_ready = ($urandom_range(0, 2) != 0);
      din_insn   = rand_insn();
      din_rs1    = $urandom();
      din_rs2    = $urandom();
      din_rs3    = $urandom();
      step();
    end
    reset = 1'b0; din_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
